// File: rtl/ct_had_pcfifo_mlane.sv
// Multi-lane change-of-flow PC trace FIFO; optional HAD_PCFIFO_STOP_ON_FULL_EN keeps oldest on full.
// Input to storage in 2 cycles; no backpressure, overflow overwrites oldest (or drops newest in stop mode).
module ct_had_pcfifo_mlane #(
  parameter int LANES    = 4,
  parameter int DEPTH    = 16,
  parameter int PC_WIDTH = 39,
  parameter int DATAW    = 64
) (
  input  logic                      cpuclk,
  input  logic                      cpurst_b,
  input  logic                      ctrl_pcfifo_wen,
  input  logic                      ctrl_pcfifo_ren,
  input  logic                      ctrl_pcfifo_clr,
  input  logic                      mmu_xx_mmu_en,
`ifdef HAD_PCFIFO_STOP_ON_FULL_EN
  input  logic                      ctrl_pcfifo_stop_mode,
`endif
  input  logic [LANES-1:0]          rtu_had_xx_pcfifo_chgflow,
  input  logic [LANES*PC_WIDTH-1:0] rtu_had_xx_pcfifo_next_pc,
  output logic [DATAW-1:0]          pcfifo_regs_data,
  output logic [$clog2(DEPTH):0]    pcfifo_cnt,
  output logic                      pcfifo_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = PC_WIDTH + 1;

  logic [LANES-1:0]    chg_q, chg_d;
  logic                wen_q, wen_d;
  logic [PC_WIDTH-1:0] pc_q [LANES];
  logic [PC_WIDTH-1:0] pc_d [LANES];
  logic [EW-1:0]       mem_q [DEPTH];
  logic [EW-1:0]       mem_d [DEPTH];
  logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [EW-1:0]       rdat_q, rdat_d;

  logic [PW:0]   n, n_acc, occ, total, drop_ow, drop, k;
  logic          rd, lost;
  logic [AW-1:0] idx;
`ifdef HAD_PCFIFO_STOP_ON_FULL_EN
  logic [PW:0]   space;
`endif

  always_comb begin
    chg_d = ctrl_pcfifo_clr ? '0 : rtu_had_xx_pcfifo_chgflow;
    wen_d = ctrl_pcfifo_wen;
    for (int i = 0; i < LANES; i++) begin
      pc_d[i] = pc_q[i];
      if (rtu_had_xx_pcfifo_chgflow[i]) pc_d[i] = rtu_had_xx_pcfifo_next_pc[i*PC_WIDTH +: PC_WIDTH];
    end
  end

  always_comb begin
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + (PW+1)'(chg_q[i]);
    if (!wen_q) n = '0;
    rd      = ctrl_pcfifo_ren && (cnt_q != '0);
    occ     = (PW+1)'(cnt_q) - (PW+1)'(rd);
    total   = occ + n;
    drop_ow = (total > (PW+1)'(DEPTH)) ? total - (PW+1)'(DEPTH) : '0;
`ifdef HAD_PCFIFO_STOP_ON_FULL_EN
    space = (PW+1)'(DEPTH) - occ;
    if (ctrl_pcfifo_stop_mode) begin
      n_acc = (n > space) ? space : n;
      drop  = '0;
      lost  = (n > space);
    end else begin
      n_acc = n;
      drop  = drop_ow;
      lost  = (drop_ow != '0);
    end
`else
    n_acc = n;
    drop  = drop_ow;
    lost  = (drop_ow != '0);
`endif

    // Compact valid lanes into consecutive slots; k counts lanes already placed.
    for (int j = 0; j < DEPTH; j++) mem_d[j] = mem_q[j];
    k   = '0;
    idx = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = wptr_q[AW-1:0] + k[AW-1:0];
      if (wen_q && chg_q[i] && (k < n_acc)) begin
        mem_d[idx] = {pc_q[i], 1'b0};
        k = k + (PW+1)'(1);
      end
    end

    wptr_d = wptr_q + PW'(n_acc);
    rptr_d = rptr_q + PW'(drop) + PW'(rd);
    cnt_d  = PW'(occ + n_acc - drop);
    ovf_d  = ovf_q | lost;
    rdat_d = rdat_q;
    if (ctrl_pcfifo_ren) rdat_d = rd ? mem_q[rptr_q[AW-1:0]] : '0;

    if (ctrl_pcfifo_clr) begin
      for (int j = 0; j < DEPTH; j++) mem_d[j] = mem_q[j];
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      rdat_d = '0;
    end
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      chg_q  <= '0;
      wen_q  <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      rdat_q <= '0;
      for (int i = 0; i < LANES; i++) pc_q[i] <= '0;
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
    end else begin
      chg_q  <= chg_d;
      wen_q  <= wen_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      rdat_q <= rdat_d;
      for (int i = 0; i < LANES; i++) pc_q[i] <= pc_d[i];
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= mem_d[j];
    end
  end

  assign pcfifo_regs_data = mmu_xx_mmu_en ? {{(DATAW-EW){rdat_q[EW-1]}}, rdat_q}
                                          : {{(DATAW-EW){1'b0}}, rdat_q};
  assign pcfifo_cnt       = cnt_q;
  assign pcfifo_ovf       = ovf_q;

endmodule

// File: tb/tb_ct_had_pcfifo_mlane.sv
// Scoreboard bench for ct_had_pcfifo_mlane: a queue model tracks stored entries, reads pop it.
module tb_ct_had_pcfifo_mlane;
  localparam int LANES = 4;
  localparam int DEPTH = 16;
  localparam int PCW   = 39;
  localparam int DATAW = 64;
  localparam int EW    = PCW + 1;

  logic                  cpuclk = 1'b0;
  logic                  cpurst_b = 1'b0;
  logic                  ctrl_pcfifo_wen = 1'b0;
  logic                  ctrl_pcfifo_ren = 1'b0;
  logic                  ctrl_pcfifo_clr = 1'b0;
  logic                  mmu_xx_mmu_en = 1'b0;
  logic                  stop_mode = 1'b0;
  logic [LANES-1:0]      chgflow = '0;
  logic [LANES*PCW-1:0]  next_pc = '0;
  logic [DATAW-1:0]      pcfifo_regs_data;
  logic [$clog2(DEPTH):0] pcfifo_cnt;
  logic                  pcfifo_ovf;

  ct_had_pcfifo_mlane #(.LANES(LANES), .DEPTH(DEPTH), .PC_WIDTH(PCW), .DATAW(DATAW)) dut (
    .cpuclk                    (cpuclk),
    .cpurst_b                  (cpurst_b),
    .ctrl_pcfifo_wen           (ctrl_pcfifo_wen),
    .ctrl_pcfifo_ren           (ctrl_pcfifo_ren),
    .ctrl_pcfifo_clr           (ctrl_pcfifo_clr),
    .mmu_xx_mmu_en             (mmu_xx_mmu_en),
`ifdef HAD_PCFIFO_STOP_ON_FULL_EN
    .ctrl_pcfifo_stop_mode     (stop_mode),
`endif
    .rtu_had_xx_pcfifo_chgflow (chgflow),
    .rtu_had_xx_pcfifo_next_pc (next_pc),
    .pcfifo_regs_data          (pcfifo_regs_data),
    .pcfifo_cnt                (pcfifo_cnt),
    .pcfifo_ovf                (pcfifo_ovf)
  );

  always #5 cpuclk = ~cpuclk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [EW-1:0] sb_q[$];
  logic [EW-1:0] pend_q[$];
  logic          pend_wen = 1'b0;
  logic          m_ovf = 1'b0;
  logic [EW-1:0] m_rdat = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ext(input logic [EW-1:0] e, input logic sx);
    return sx ? {{(64-EW){e[EW-1]}}, e} : {{(64-EW){1'b0}}, e};
  endfunction

  function automatic logic [LANES*PCW-1:0] pv(input logic [PCW-1:0] p0, p1, p2, p3);
    return {p3, p2, p1, p0};
  endfunction

  // One clock: drive inputs, advance the model by the same edge, then check outputs.
  task automatic cyc(input logic [LANES-1:0] chg, input logic [LANES*PCW-1:0] pcs,
                     input logic wen, input logic ren, input logic clr);
    chgflow = chg;
    next_pc = pcs;
    ctrl_pcfifo_wen = wen;
    ctrl_pcfifo_ren = ren;
    ctrl_pcfifo_clr = clr;
    if (clr) begin
      sb_q.delete();
      pend_q.delete();
      m_ovf  = 1'b0;
      m_rdat = '0;
    end else begin
      if (ren) m_rdat = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      if (pend_wen) begin
        foreach (pend_q[j]) begin
          if (stop_mode && sb_q.size() == DEPTH) m_ovf = 1'b1;
          else begin
            sb_q.push_back(pend_q[j]);
            if (sb_q.size() > DEPTH) begin
              void'(sb_q.pop_front());
              m_ovf = 1'b1;
            end
          end
        end
      end
      pend_q.delete();
      for (int i = 0; i < LANES; i++)
        if (chg[i]) pend_q.push_back({pcs[i*PCW +: PCW], 1'b0});
    end
    pend_wen = wen;
    @(posedge cpuclk);
    #1;
    chk("cnt", 64'(pcfifo_cnt), 64'(sb_q.size()));
    chk("ovf", 64'(pcfifo_ovf), 64'(m_ovf));
    chk("rdat", pcfifo_regs_data, ext(m_rdat, mmu_xx_mmu_en));
  endtask

  task automatic idle();
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd1();
    cyc('0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [LANES*PCW-1:0] rp;
    #12;
    chk("rst_cnt", 64'(pcfifo_cnt), 64'd0);
    chk("rst_ovf", 64'(pcfifo_ovf), 64'd0);
    chk("rst_rdat", pcfifo_regs_data, 64'd0);
    @(negedge cpuclk);
    cpurst_b = 1'b1;

    // lane order and {pc,0} entry format
    cyc(4'b1010, pv(39'h0, 39'h100, 39'h0, 39'h300), 1'b1, 1'b0, 1'b0);
    idle();
    chk("basic_cnt", 64'(pcfifo_cnt), 64'd2);
    rd1();
    chk("basic_rd0", pcfifo_regs_data, 64'h200);
    rd1();
    chk("basic_rd1", pcfifo_regs_data, 64'h600);

    // fill to full, then overflow by three
    for (int w = 0; w < 4; w++)
      cyc(4'hf, pv(39'(32'h1000 + 4*w), 39'(32'h1001 + 4*w), 39'(32'h1002 + 4*w), 39'(32'h1003 + 4*w)),
          1'b1, 1'b0, 1'b0);
    cyc(4'b1101, pv(39'h1010, 39'h1ff, 39'h1011, 39'h1012), 1'b1, 1'b0, 1'b0);
    chk("full_cnt", 64'(pcfifo_cnt), 64'd16);
    chk("full_ovf", 64'(pcfifo_ovf), 64'd0);
    cyc(4'b0001, pv(39'h1013, 39'h0, 39'h0, 39'h0), 1'b1, 1'b0, 1'b0);
    chk("ovf_cnt", 64'(pcfifo_cnt), 64'd16);
    chk("ovf_flag", 64'(pcfifo_ovf), 64'd1);
    // read while a one-lane write lands at full
    rd1();
    chk("rw_rdat", pcfifo_regs_data, 64'h2006);
    chk("rw_cnt", 64'(pcfifo_cnt), 64'd16);
    for (int i = 0; i < 16; i++) rd1();
    rd1();
    chk("empty_rdat", pcfifo_regs_data, 64'd0);
    chk("empty_cnt", 64'(pcfifo_cnt), 64'd0);

    // sign / zero extension of the stored entry
    cyc(4'b0001, pv(39'h40_0000_0000, 39'h0, 39'h0, 39'h0), 1'b1, 1'b0, 1'b0);
    idle();
    rd1();
    mmu_xx_mmu_en = 1'b1;
    #1;
    chk("sext", pcfifo_regs_data, 64'hFFFF_FF80_0000_0000);
    mmu_xx_mmu_en = 1'b0;
    #1;
    chk("zext", pcfifo_regs_data, 64'h0000_0080_0000_0000);

    // clear beats a landing write and a read; wen=0 gates stage-1 data
    cyc(4'hf, pv(39'h11, 39'h12, 39'h13, 39'h14), 1'b1, 1'b0, 1'b0);
    cyc(4'hf, pv(39'h21, 39'h22, 39'h23, 39'h24), 1'b1, 1'b0, 1'b0);
    cyc(4'hf, pv(39'h31, 39'h32, 39'h33, 39'h34), 1'b1, 1'b1, 1'b1);
    chk("clr_cnt", 64'(pcfifo_cnt), 64'd0);
    chk("clr_ovf", 64'(pcfifo_ovf), 64'd0);
    chk("clr_rdat", pcfifo_regs_data, 64'd0);
    idle();
    cyc(4'b0001, pv(39'h55, 39'h0, 39'h0, 39'h0), 1'b1, 1'b0, 1'b0);
    cyc(4'hf, pv(39'h61, 39'h62, 39'h63, 39'h64), 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    chk("gate_cnt", 64'(pcfifo_cnt), 64'd1);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < LANES; l++) rp[l*PCW +: PCW] = {7'($urandom), $urandom};
      mmu_xx_mmu_en = 1'($urandom);
`ifdef HAD_PCFIFO_STOP_ON_FULL_EN
      stop_mode = ($urandom_range(0, 3) == 0);
`endif
      cyc(4'($urandom), rp, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 60) == 0);
    end
    stop_mode = 1'b0;

    // asynchronous reset in mid-cycle
    cyc(4'hf, pv(39'h71, 39'h72, 39'h73, 39'h74), 1'b1, 1'b0, 1'b0);
    idle();
    rd1();
    #2;
    cpurst_b = 1'b0;
    #1;
    chk("arst_cnt", 64'(pcfifo_cnt), 64'd0);
    chk("arst_ovf", 64'(pcfifo_ovf), 64'd0);
    chk("arst_rdat", pcfifo_regs_data, 64'd0);
    sb_q.delete();
    pend_q.delete();
    pend_wen = 1'b0;
    m_ovf    = 1'b0;
    m_rdat   = '0;
    @(negedge cpuclk);
    cpurst_b = 1'b1;
    idle();

`ifdef HAD_PCFIFO_STOP_ON_FULL_EN
    // stop mode keeps the oldest entries and drops excess lanes
    for (int w = 0; w < 3; w++)
      cyc(4'hf, pv(39'(32'h1000 + 4*w), 39'(32'h1001 + 4*w), 39'(32'h1002 + 4*w), 39'(32'h1003 + 4*w)),
          1'b1, 1'b0, 1'b0);
    cyc(4'b0011, pv(39'h100c, 39'h100d, 39'h0, 39'h0), 1'b1, 1'b0, 1'b0);
    idle();
    chk("stop_pre_cnt", 64'(pcfifo_cnt), 64'd14);
    stop_mode = 1'b1;
    cyc(4'hf, pv(39'h2000, 39'h2001, 39'h2002, 39'h2003), 1'b1, 1'b0, 1'b0);
    idle();
    chk("stop_cnt", 64'(pcfifo_cnt), 64'd16);
    chk("stop_ovf", 64'(pcfifo_ovf), 64'd1);
    rd1();
    chk("stop_oldest", pcfifo_regs_data, 64'h2000);
    stop_mode = 1'b0;
    idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
